// File: rtl/st_frame_capture.sv
// Captures one Avalon-ST video frame on request and streams it as RGB565 writes
// into an SDRAM write FIFO, flagging short frames and holding a completion level.
module st_frame_capture #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        capture_req,
  input  logic [23:0] st_data,
  input  logic        st_valid,
  input  logic        st_sop,
  input  logic        st_eop,
  output logic        st_ready,
  input  logic        wr_full,
  output logic        wr_req,
  output logic [15:0] wr_data,
  output logic        img_captured,
  output logic        frame_error,
  output logic [18:0] pixel_count,
  output logic [1:0]  state_dbg
);

  // Stream handshake: a beat transfers on a rising edge where st_valid and
  // st_ready are both high; st_ready never waits on st_valid.
  localparam logic [18:0] PIX_MAX = 19'(H_ACTIVE * V_ACTIVE);

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

  state_t      state_q, state_d;
  logic        ready_en_q;
  logic        accept;
  logic        is_video_sop;
  logic        wr_req_d;
  logic        img_d;
  logic        err_d;
  logic [18:0] count_d;
  logic        unused_bits;

  assign unused_bits = ^{st_data[18:16], st_data[9:8]};
  assign state_dbg   = state_q;

  // ready_en keeps st_ready low during reset and for the edge that releases it.
  assign st_ready     = ready_en_q & ((state_q == CAPTURE) ? ~wr_full : 1'b1);
  assign accept       = st_valid & st_ready;
  assign is_video_sop = accept & st_sop & (st_data[3:0] == 4'h0);

  always_comb begin
    state_d  = state_q;
    count_d  = pixel_count;
    img_d    = img_captured;
    err_d    = 1'b0;
    wr_req_d = 1'b0;
    case (state_q)
      IDLE: begin
        count_d = '0;
        if (capture_req) state_d = ARMED;
      end
      ARMED: begin
        if (is_video_sop) state_d = CAPTURE;
      end
      CAPTURE: begin
        if (accept && st_sop) begin
          // A new packet before EOP abandons the frame; the SOP is judged as if armed.
          err_d   = 1'b1;
          count_d = '0;
          state_d = is_video_sop ? CAPTURE : ARMED;
        end else if (accept) begin
          if (pixel_count < PIX_MAX) begin
            wr_req_d = 1'b1;
            count_d  = pixel_count + 19'd1;
          end
          if (st_eop) begin
            if (count_d == PIX_MAX) begin
              state_d = DONE;
              img_d   = 1'b1;
            end else begin
              err_d   = 1'b1;
              count_d = '0;
              state_d = ARMED;
            end
          end
        end
      end
      DONE: begin
        if (capture_req) begin
          state_d = ARMED;
          img_d   = 1'b0;
          count_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      ready_en_q   <= 1'b0;
      wr_req       <= 1'b0;
      wr_data      <= '0;
      img_captured <= 1'b0;
      frame_error  <= 1'b0;
      pixel_count  <= '0;
    end else begin
      state_q      <= state_d;
      ready_en_q   <= 1'b1;
      wr_req       <= wr_req_d;
      img_captured <= img_d;
      frame_error  <= err_d;
      pixel_count  <= count_d;
      if (wr_req_d) wr_data <= {st_data[23:19], st_data[15:10], st_data[7:3]};
    end
  end

endmodule

// File: tb/tb_st_frame_capture.sv
// Scoreboard bench for st_frame_capture: packet-level reference model feeds an
// expected write queue that a monitor drains whenever wr_req is seen.
module tb_st_frame_capture;
  localparam int H = 4;
  localparam int V = 2;
  localparam int MAX = H * V;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        capture_req;
  logic [23:0] st_data;
  logic        st_valid, st_sop, st_eop;
  logic        st_ready;
  logic        wr_full;
  logic        wr_req;
  logic [15:0] wr_data;
  logic        img_captured, frame_error;
  logic [18:0] pixel_count;
  logic [1:0]  state_dbg;

  st_frame_capture #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
    .clk(clk), .reset_n(reset_n), .capture_req(capture_req),
    .st_data(st_data), .st_valid(st_valid), .st_sop(st_sop), .st_eop(st_eop),
    .st_ready(st_ready), .wr_full(wr_full), .wr_req(wr_req), .wr_data(wr_data),
    .img_captured(img_captured), .frame_error(frame_error),
    .pixel_count(pixel_count), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // Scoreboard state
  logic [15:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int wr_seen = 0;
  int err_seen = 0;
  int exp_total = 0;

  // Reference model: 0 idle, 1 armed, 2 capturing, 3 done
  int m_state = 0;
  int m_count = 0;
  int m_img = 0;
  int m_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] to565(input logic [23:0] p);
    int r, g, b;
    r = p[23:16] / 8;
    g = p[15:8] / 4;
    b = p[7:0] / 8;
    return 16'(r * 2048 + g * 32 + b);
  endfunction

  // Monitor
  always @(negedge clk) begin
    if (reset_n && wr_req) begin
      wr_seen++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected: got write %0h expected none", wr_data);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        checks--;
        chk("wr_data", 32'(wr_data), 32'(e));
      end
    end
    if (reset_n && frame_error) err_seen++;
  end

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drive_beat(input logic [23:0] d, input logic sop, input logic eop, input bit rnd);
    bit ok;
    ok = 1'b0;
    st_data = d; st_sop = sop; st_eop = eop; st_valid = 1'b1;
    for (int t = 0; t < 200 && !ok; t++) begin
      if (rnd) wr_full = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      ok = st_ready;
      @(posedge clk); #1;
    end
    if (!ok) chk("beat_timeout", 32'(0), 32'(1));
    st_valid = 1'b0; st_sop = 1'b0; st_eop = 1'b0;
    wr_full = 1'b0;
    if (rnd) idle_cycles($urandom_range(0, 2));
  endtask

  task automatic do_capture_req();
    capture_req = 1'b1;
    @(posedge clk); #1;
    capture_req = 1'b0;
    if (m_state == 0 || m_state == 3) begin
      m_state = 1; m_img = 0; m_count = 0;
    end
  endtask

  task automatic send_packet(input logic [3:0] typ, input int n, input bit eop,
                             input bit fixed, input logic [23:0] fix_pix,
                             input int stall_at, input bit rnd);
    logic [23:0] pix;
    logic [23:0] sop_d;
    bool_video: begin end
    if (m_state == 2) begin
      m_err++; m_count = 0; m_state = 1;
    end
    if (m_state == 1 && typ == 4'h0) m_state = 2;
    sop_d = 24'($urandom);
    sop_d[3:0] = typ;
    drive_beat(sop_d, 1'b1, 1'b0, rnd);
    for (int i = 0; i < n; i++) begin
      pix = fixed ? fix_pix : 24'($urandom);
      if (m_state == 2 && typ == 4'h0 && m_count < MAX) begin
        exp_q.push_back(to565(pix));
        exp_total++;
        m_count++;
      end
      if (i == stall_at) begin
        wr_full = 1'b1;
        st_data = pix; st_sop = 1'b0; st_eop = 1'b0; st_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          chk("stall_ready", 32'(st_ready), 32'(0));
          @(posedge clk); #1;
        end
        wr_full = 1'b0;
      end
      drive_beat(pix, 1'b0, eop && (i == n - 1), rnd);
    end
    if (eop && m_state == 2) begin
      if (m_count == MAX) begin
        m_state = 3; m_img = 1;
      end else begin
        m_err++; m_count = 0; m_state = 1;
      end
    end
  endtask

  task automatic check_status(input string tag);
    idle_cycles(2);
    @(negedge clk);
    chk({tag, "_img"}, 32'(img_captured), 32'(m_img));
    chk({tag, "_count"}, 32'(pixel_count), 32'(m_count));
    chk({tag, "_errs"}, 32'(err_seen), 32'(m_err));
    chk({tag, "_qempty"}, 32'(exp_q.size()), 32'(0));
    @(posedge clk); #1;
  endtask

  task automatic check_reset_values();
    @(negedge clk);
    chk("rst_state", 32'(state_dbg), 32'(0));
    chk("rst_ready", 32'(st_ready), 32'(0));
    chk("rst_wr_req", 32'(wr_req), 32'(0));
    chk("rst_wr_data", 32'(wr_data), 32'(0));
    chk("rst_img", 32'(img_captured), 32'(0));
    chk("rst_err", 32'(frame_error), 32'(0));
    chk("rst_count", 32'(pixel_count), 32'(0));
  endtask

  initial begin
    int w0;
    reset_n = 1'b0; capture_req = 1'b0; st_data = '0;
    st_valid = 1'b0; st_sop = 1'b0; st_eop = 1'b0; wr_full = 1'b0;
    repeat (2) @(posedge clk);
    check_reset_values();
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("ready_before_edge", 32'(st_ready), 32'(0));
    @(posedge clk); #1;
    chk("ready_after_edge", 32'(st_ready), 32'(1));

    // Basic capture: control packet ignored, fixed-colour video frame written
    w0 = wr_seen;
    do_capture_req();
    send_packet(4'hF, 3, 1'b1, 1'b0, 24'h0, -1, 1'b0);
    send_packet(4'h0, MAX, 1'b1, 1'b1, 24'hFF8040, -1, 1'b0);
    check_status("basic");
    chk("basic_writes", 32'(wr_seen - w0), 32'(MAX));
    chk("basic_data", 32'(wr_data), 32'h0000FC08);

    // Five-cycle FIFO stall mid-frame
    w0 = wr_seen;
    do_capture_req();
    @(negedge clk);
    chk("rearm_state", 32'(state_dbg), 32'(1));
    chk("rearm_count", 32'(pixel_count), 32'(0));
    chk("rearm_img", 32'(img_captured), 32'(0));
    @(posedge clk); #1;
    send_packet(4'h0, MAX, 1'b1, 1'b1, 24'hFF8040, 4, 1'b0);
    check_status("stall");
    chk("stall_writes", 32'(wr_seen - w0), 32'(MAX));

    // Short frame then a complete one
    do_capture_req();
    send_packet(4'h0, 5, 1'b1, 1'b0, 24'h0, -1, 1'b0);
    check_status("short");
    @(negedge clk);
    chk("short_state", 32'(state_dbg), 32'(1));
    @(posedge clk); #1;
    send_packet(4'h0, MAX, 1'b1, 1'b0, 24'h0, -1, 1'b0);
    check_status("after_short");

    // Oversized frame: extra beats dropped
    w0 = wr_seen;
    do_capture_req();
    send_packet(4'h0, 10, 1'b1, 1'b0, 24'h0, -1, 1'b0);
    check_status("long");
    chk("long_writes", 32'(wr_seen - w0), 32'(MAX));

    // SOP arriving before EOP aborts the frame, new packet restarts it
    do_capture_req();
    send_packet(4'h0, 3, 1'b0, 1'b0, 24'h0, -1, 1'b0);
    send_packet(4'h0, MAX, 1'b1, 1'b0, 24'h0, -1, 1'b0);
    check_status("resop");

    // Randomized packets with random back-pressure and gaps
    for (int k = 0; k < 25; k++) begin
      if (m_state == 3 && $urandom_range(0, 2) != 0) do_capture_req();
      else if ($urandom_range(0, 7) == 0) do_capture_req();
      send_packet(($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'h0,
                  $urandom_range(1, 12), 1'b1, 1'b0, 24'h0, -1, 1'b1);
      check_status("rand");
    end

    // Reset mid-frame after three written pixels
    if (m_state == 3) do_capture_req();
    if (m_state == 0) do_capture_req();
    send_packet(4'h0, 3, 1'b0, 1'b0, 24'h0, -1, 1'b0);
    idle_cycles(2);
    #2 reset_n = 1'b0;
    m_state = 0; m_count = 0; m_img = 0;
    check_reset_values();
    @(posedge clk); #1;
    reset_n = 1'b1;
    idle_cycles(1);
    w0 = wr_seen;
    send_packet(4'h0, MAX, 1'b1, 1'b0, 24'h0, -1, 1'b0);
    check_status("post_rst_idle");
    chk("post_rst_nowrite", 32'(wr_seen - w0), 32'(0));
    do_capture_req();
    send_packet(4'h0, MAX, 1'b1, 1'b0, 24'h0, -1, 1'b0);
    check_status("post_rst_cap");

    chk("total_writes", 32'(wr_seen), 32'(exp_total));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
